// File: rtl/xdma_pkg.sv
// Shared XDMA types: grant descriptor/payload layouts, AXI response codes, MMIO offsets.
package xdma_pkg;

  // remote_addr sits in the LSBs so a plain width cast extracts it.
  typedef struct packed {
    logic [7:0]  dma_id;
    logic [47:0] remote_addr;
  } xdma_req_desc_t;

  typedef struct packed {
    logic [7:0] dma_id;
    logic [7:0] grant;
  } xdma_to_remote_grant_t;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitB
  } gw_state_e;

  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespExOkay = 2'b01;
  localparam logic [1:0] AxiRespSlvErr = 2'b10;
  localparam logic [1:0] AxiRespDecErr = 2'b11;

  localparam logic [47:0] MMIOGrantOffset = 48'h0000_0000_0100;

endpackage

// File: rtl/xdma_grant_writer.sv
// Single-beat AXI write of a captured grant to a remote address, with bounded
// resend on error responses and one outstanding write at a time.
module xdma_grant_writer #(
  parameter type         xdma_req_desc_t        = logic,
  parameter type         xdma_to_remote_grant_t = logic,
  parameter int unsigned AddrWidth              = 48,
  parameter int unsigned DataWidth              = 64,
  parameter int unsigned MaxRetry               = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  xdma_req_desc_t         grant_desc_i,
  input  xdma_to_remote_grant_t  grant_i,
  input  logic                   grant_valid_i,
  output logic                   grant_ready_o,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  output logic                   w_last_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  input  logic [1:0]             b_resp_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [15:0]            sent_cnt_o
);

  localparam int unsigned RetryW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;

  xdma_pkg::gw_state_e r_state, w_state_d;

  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_data;
  logic [RetryW-1:0]    r_retry;
  logic                 r_aw_done, r_w_done, r_err;
  logic [15:0]          r_cnt;

  logic [$bits(xdma_req_desc_t)-1:0]        w_desc_bits;
  logic [$bits(xdma_to_remote_grant_t)-1:0] w_grant_bits;
  logic w_accept, w_aw_fire, w_w_fire, w_resp_ok, w_resp_retry, w_resp_drop;

  assign w_desc_bits  = grant_desc_i;
  assign w_grant_bits = grant_i;
  assign w_aw_fire    = aw_valid_o & aw_ready_i;
  assign w_w_fire     = w_valid_o & w_ready_i;

  assign aw_addr_o  = r_addr;
  assign w_data_o   = r_data;
  assign w_strb_o   = '1;
  assign w_last_o   = 1'b1;
  assign err_o      = r_err;
  assign sent_cnt_o = r_cnt;

  always_comb begin
    w_state_d     = r_state;
    grant_ready_o = 1'b0;
    b_ready_o     = 1'b0;
    busy_o        = 1'b1;
    aw_valid_o    = 1'b0;
    w_valid_o     = 1'b0;
    w_accept      = 1'b0;
    w_resp_ok     = 1'b0;
    w_resp_retry  = 1'b0;
    w_resp_drop   = 1'b0;
    unique case (r_state)
      xdma_pkg::StIdle: begin
        grant_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (grant_valid_i) begin
          w_accept  = 1'b1;
          w_state_d = xdma_pkg::StSend;
        end
      end
      xdma_pkg::StSend: begin
        aw_valid_o = ~r_aw_done;
        w_valid_o  = ~r_w_done;
        if ((r_aw_done | aw_ready_i) && (r_w_done | w_ready_i)) begin
          w_state_d = xdma_pkg::StWaitB;
        end
      end
      xdma_pkg::StWaitB: begin
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          // OKAY and EXOKAY both have bit 1 clear.
          if (!b_resp_i[1]) begin
            w_resp_ok = 1'b1;
            w_state_d = xdma_pkg::StIdle;
          end else if (r_retry < RetryW'(MaxRetry)) begin
            w_resp_retry = 1'b1;
            w_state_d    = xdma_pkg::StSend;
          end else begin
            w_resp_drop = 1'b1;
            w_state_d   = xdma_pkg::StIdle;
          end
        end
      end
      default: w_state_d = xdma_pkg::StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= xdma_pkg::StIdle;
      r_addr    <= '0;
      r_data    <= '0;
      r_retry   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_resp_drop;
      if (w_accept) begin
        r_addr  <= AddrWidth'(w_desc_bits);
        r_data  <= DataWidth'(w_grant_bits);
        r_retry <= '0;
      end
      // Done flags live only for the current attempt.
      if (w_state_d != xdma_pkg::StSend) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        r_aw_done <= r_aw_done | w_aw_fire;
        r_w_done  <= r_w_done | w_w_fire;
      end
      if (w_resp_retry) r_retry <= r_retry + 1'b1;
      if (w_resp_ok)    r_cnt   <= r_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_xdma_grant_writer.sv
// Directed bench for xdma_grant_writer: handshakes, stalls, retries, drop, capture, reset.
module tb_xdma_grant_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  xdma_pkg::xdma_req_desc_t        grant_desc = '0;
  xdma_pkg::xdma_to_remote_grant_t grant = '0;
  logic        grant_valid = 1'b0;
  logic        grant_ready;
  logic [47:0] aw_addr;
  logic        aw_valid, aw_ready = 1'b0;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last, w_valid, w_ready = 1'b0;
  logic [1:0]  b_resp = 2'b00;
  logic        b_valid = 1'b0;
  logic        b_ready, busy, err;
  logic [15:0] sent_cnt;

  int vectors = 0;
  int miscompares = 0;
  int aw_hs = 0, w_hs = 0, err_hs = 0;
  logic [47:0] last_aw_addr = '0;
  logic [63:0] last_w_data = '0;

  xdma_grant_writer #(
    .xdma_req_desc_t       (xdma_pkg::xdma_req_desc_t),
    .xdma_to_remote_grant_t(xdma_pkg::xdma_to_remote_grant_t),
    .AddrWidth             (48),
    .DataWidth             (64),
    .MaxRetry              (3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .grant_desc_i (grant_desc),
    .grant_i      (grant),
    .grant_valid_i(grant_valid),
    .grant_ready_o(grant_ready),
    .aw_addr_o    (aw_addr),
    .aw_valid_o   (aw_valid),
    .aw_ready_i   (aw_ready),
    .w_data_o     (w_data),
    .w_strb_o     (w_strb),
    .w_last_o     (w_last),
    .w_valid_o    (w_valid),
    .w_ready_i    (w_ready),
    .b_resp_i     (b_resp),
    .b_valid_i    (b_valid),
    .b_ready_o    (b_ready),
    .busy_o       (busy),
    .err_o        (err),
    .sent_cnt_o   (sent_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (aw_valid && aw_ready) begin
        aw_hs++;
        last_aw_addr = aw_addr;
      end
      if (w_valid && w_ready) begin
        w_hs++;
        last_w_data = w_data;
      end
      if (err) err_hs++;
    end
  end

  task automatic send_grant(input logic [47:0] addr, input logic [7:0] id, input logic [7:0] g);
    @(negedge clk);
    grant_desc.remote_addr = addr;
    grant_desc.dma_id      = id;
    grant.dma_id           = id;
    grant.grant            = g;
    grant_valid            = 1'b1;
    @(negedge clk);
    grant_valid = 1'b0;
  endtask

  task automatic wait_b(input string tag);
    int n = 0;
    while (!b_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s wait_b: b_ready=%b required 1 within 20 cycles", tag, b_ready);
    end
  endtask

  task automatic respond(input logic [1:0] resp);
    b_valid = 1'b1;
    b_resp  = resp;
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if ({grant_ready, aw_valid, w_valid, b_ready, busy, err} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: {grdy,awv,wv,brdy,busy,err}=%b required 100000",
               {grant_ready, aw_valid, w_valid, b_ready, busy, err});
    end
    vectors++;
    if (sent_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d required 0", sent_cnt);
    end
  endtask

  task automatic test_basic;
    int aw0 = aw_hs;
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    send_grant(48'h0000_1000_0FF0, 8'h00, 8'hAB);
    vectors++;
    if ({aw_valid, w_valid, busy, grant_ready} !== 4'b1110) begin
      miscompares++;
      $display("FAIL basic_send: {awv,wv,busy,grdy}=%b required 1110",
               {aw_valid, w_valid, busy, grant_ready});
    end
    vectors++;
    if (aw_addr !== 48'h0000_1000_0FF0 || w_data !== 64'hAB || w_strb !== 8'hFF || w_last !== 1'b1)
    begin
      miscompares++;
      $display("FAIL basic_payload: addr=%h data=%h strb=%h last=%b required 000010000ff0 ab ff 1",
               aw_addr, w_data, w_strb, w_last);
    end
    @(negedge clk);
    vectors++;
    if ({b_ready, aw_valid, w_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL basic_waitb: {brdy,awv,wv}=%b required 100", {b_ready, aw_valid, w_valid});
    end
    respond(xdma_pkg::AxiRespOkay);
    vectors++;
    if (sent_cnt !== 16'd1 || grant_ready !== 1'b1 || busy !== 1'b0 || b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: cnt=%0d grdy=%b busy=%b brdy=%b required 1 1 0 0",
               sent_cnt, grant_ready, busy, b_ready);
    end
    vectors++;
    if (aw_hs - aw0 !== 1) begin
      miscompares++;
      $display("FAIL basic_aw_count: got %0d required 1", aw_hs - aw0);
    end
  endtask

  task automatic test_w_stall;
    int aw0 = aw_hs;
    int w0  = w_hs;
    aw_ready = 1'b1;
    w_ready  = 1'b0;
    send_grant(48'h0000_0000_2000, 8'h01, 8'h11);
    vectors++;
    if ({aw_valid, w_valid} !== 2'b11) begin
      miscompares++;
      $display("FAIL stall_start: {awv,wv}=%b required 11", {aw_valid, w_valid});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({aw_valid, w_valid, b_ready} !== 3'b010) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: {awv,wv,brdy}=%b required 010", i,
                 {aw_valid, w_valid, b_ready});
      end
    end
    w_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({b_ready, w_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_waitb: {brdy,wv}=%b required 10", {b_ready, w_valid});
    end
    vectors++;
    if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
      miscompares++;
      $display("FAIL stall_counts: aw=%0d w=%0d required 1 1", aw_hs - aw0, w_hs - w0);
    end
    respond(xdma_pkg::AxiRespExOkay);
    vectors++;
    if (sent_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d required 2", sent_cnt);
    end
  endtask

  task automatic test_retry;
    int aw0 = aw_hs;
    int e0  = err_hs;
    logic [1:0] resps [3] = '{xdma_pkg::AxiRespSlvErr, xdma_pkg::AxiRespSlvErr,
                              xdma_pkg::AxiRespOkay};
    send_grant(48'h0000_0000_3008, 8'h02, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      wait_b("retry");
      vectors++;
      if (last_aw_addr !== 48'h0000_0000_3008 || last_w_data !== 64'h025A) begin
        miscompares++;
        $display("FAIL retry_attempt[%0d]: addr=%h data=%h required 000000003008 025a", i,
                 last_aw_addr, last_w_data);
      end
      respond(resps[i]);
    end
    vectors++;
    if (aw_hs - aw0 !== 3 || sent_cnt !== 16'd3 || err_hs != e0) begin
      miscompares++;
      $display("FAIL retry_result: attempts=%0d cnt=%0d errs=%0d required 3 3 0",
               aw_hs - aw0, sent_cnt, err_hs - e0);
    end
  endtask

  task automatic test_drop;
    int aw0 = aw_hs;
    int e0  = err_hs;
    send_grant(48'h0000_0000_4000, 8'h03, 8'h77);
    for (int i = 0; i < 4; i++) begin
      wait_b("drop");
      respond(xdma_pkg::AxiRespDecErr);
    end
    vectors++;
    if (err !== 1'b1 || grant_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_pulse: err=%b grdy=%b busy=%b required 1 1 0", err, grant_ready, busy);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || err_hs - e0 !== 1) begin
      miscompares++;
      $display("FAIL drop_single: err=%b pulses=%0d required 0 1", err, err_hs - e0);
    end
    vectors++;
    if (aw_hs - aw0 !== 4 || sent_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL drop_result: attempts=%0d cnt=%0d required 4 3", aw_hs - aw0, sent_cnt);
    end
  endtask

  task automatic test_capture;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    send_grant(48'h0000_0000_5550, 8'h05, 8'h3C);
    grant_desc.remote_addr = 48'hFFFF_FFFF_FFFF;
    grant.grant            = 8'hEE;
    grant.dma_id           = 8'hDD;
    @(negedge clk);
    vectors++;
    if (aw_addr !== 48'h0000_0000_5550 || w_data !== 64'h053C || {aw_valid, w_valid} !== 2'b11)
    begin
      miscompares++;
      $display("FAIL capture_hold: addr=%h data=%h v=%b required 000000005550 053c 11",
               aw_addr, w_data, {aw_valid, w_valid});
    end
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    wait_b("capture");
    respond(xdma_pkg::AxiRespOkay);
    vectors++;
    if (last_w_data !== 64'h053C || sent_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL capture_done: data=%h cnt=%0d required 053c 4", last_w_data, sent_cnt);
    end
  endtask

  task automatic test_back_to_back;
    send_grant(48'h0000_0000_6000, 8'h06, 8'h01);
    wait_b("b2b");
    b_valid = 1'b1;
    b_resp  = xdma_pkg::AxiRespOkay;
    @(negedge clk);
    b_valid                = 1'b0;
    grant_desc.remote_addr = 48'h0000_0000_7000;
    grant.grant            = 8'h02;
    grant.dma_id           = 8'h07;
    grant_valid            = 1'b1;
    @(negedge clk);
    grant_valid = 1'b0;
    vectors++;
    if (aw_valid !== 1'b1 || aw_addr !== 48'h0000_0000_7000 || sent_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL b2b_accept: awv=%b addr=%h cnt=%0d required 1 000000007000 5",
               aw_valid, aw_addr, sent_cnt);
    end
    wait_b("b2b2");
    respond(xdma_pkg::AxiRespOkay);
    vectors++;
    if (sent_cnt !== 16'd6) begin
      miscompares++;
      $display("FAIL b2b_cnt: got %0d required 6", sent_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int e0 = err_hs;
    send_grant(48'h0000_0000_8000, 8'h08, 8'h99);
    wait_b("rst_mid");
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({aw_valid, w_valid, b_ready, busy, err} !== 5'b00000 || sent_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: {awv,wv,brdy,busy,err}=%b cnt=%0d required 00000 0",
               {aw_valid, w_valid, b_ready, busy, err}, sent_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (grant_ready !== 1'b1 || busy !== 1'b0 || err_hs != e0 || sent_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid_release: grdy=%b busy=%b errs=%0d cnt=%0d required 1 0 0 0",
               grant_ready, busy, err_hs - e0, sent_cnt);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_w_stall();
    test_retry();
    test_drop();
    test_capture();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
